// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a read-only fetch port (if_*) and a load/store port (ls_*)
// onto a single main_memory port, one transaction at a time.
//   clk, rst            : single clock, synchronous active-high reset
//   if_req/if_addr      : fetch request (always a read); if_gnt, if_valid, if_rdata, if_err back
//   ls_req/ls_we/ls_addr/ls_wdata : load/store request; ls_gnt, ls_valid, ls_rdata, ls_err back
//   mem_address, mem_data_in, mem_write, mem_waring (read strobe) : to memory
//   mem_done, mem_read_value : from memory
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed LS priority.
module mem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic              mem_waring,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_read_value
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;
    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              if_gnt_q, if_valid_q, if_err_q, ls_gnt_q, ls_valid_q, ls_err_q;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
    logic              pick_ls_d;
    logic              busy;
`ifdef MEM_ARB_RR_EN
    logic              last_ls_q;
    // on contention, the requester that did not win last time goes first
    assign pick_ls_d = ls_req && (!if_req || !last_ls_q);
`else
    assign pick_ls_d = ls_req;
`endif
    assign busy        = state_q != IDLE;
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_write   = busy && we_q;
    assign mem_waring  = busy && !we_q;
    assign if_gnt      = if_gnt_q;
    assign if_valid    = if_valid_q;
    assign if_err      = if_err_q;
    assign if_rdata    = if_rdata_q;
    assign ls_gnt      = ls_gnt_q;
    assign ls_valid    = ls_valid_q;
    assign ls_err      = ls_err_q;
    assign ls_rdata    = ls_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_err_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_ls_q  <= 1'b0;
`endif
        end else begin
            if_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
            ls_valid_q <= 1'b0;
            ls_err_q   <= 1'b0;
            if (state_q == IDLE) begin
                if (if_req || ls_req) begin
                    state_q  <= pick_ls_d ? BUSY_LS : BUSY_IF;
                    cnt_q    <= '0;
                    addr_q   <= pick_ls_d ? ls_addr : if_addr;
                    wdata_q  <= pick_ls_d ? ls_wdata : '0;
                    we_q     <= pick_ls_d && ls_we;
                    if_gnt_q <= !pick_ls_d;
                    ls_gnt_q <= pick_ls_d;
`ifdef MEM_ARB_RR_EN
                    last_ls_q <= pick_ls_d;
`endif
                end
            end else if (mem_done) begin
                // completion wins over a coinciding timeout
                state_q <= IDLE;
                if (state_q == BUSY_LS) begin
                    ls_valid_q <= 1'b1;
                    ls_rdata_q <= mem_read_value;
                end else begin
                    if_valid_q <= 1'b1;
                    if_rdata_q <= mem_read_value;
                end
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                // TIMEOUT BUSY cycles elapsed without completion
                state_q  <= IDLE;
                ls_err_q <= state_q == BUSY_LS;
                if_err_q <= state_q == BUSY_IF;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction-level check of mem_arbiter against a memory/arbitration model
module tb_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_done = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0, mem_read_value = '0;
    logic          if_gnt, if_valid, if_err, ls_gnt, ls_valid, ls_err, mem_write, mem_waring;
    logic [DW-1:0] if_rdata, ls_rdata, mem_data_in;
    logic [AW-1:0] mem_address;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_waring(mem_waring), .mem_done(mem_done), .mem_read_value(mem_read_value)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_if_rd = '0, exp_ls_rd = '0;
    bit            last_ls = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {if_gnt, if_valid, if_err, ls_gnt, ls_valid, ls_err, mem_write, mem_waring};
    endfunction

    // Called at a negedge while the DUT is idle and at least one request is driven.
    // lat = number of BUSY cycles before mem_done; lat >= TO means memory never answers.
    task automatic serve(input int lat, input logic [DW-1:0] junk);
        bit            ls_w, we, to;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rv;
`ifdef MEM_ARB_RR_EN
        ls_w = ls_req && (!if_req || !last_ls);
`else
        ls_w = ls_req;
`endif
        last_ls = ls_w;
        a  = ls_w ? ls_addr : if_addr;
        we = ls_w && ls_we;
        wd = ls_wdata;
        rv = we ? junk : mem[a];
        to = lat >= TO;
        @(negedge clk);
        check("if_gnt", if_gnt, !ls_w);
        check("ls_gnt", ls_gnt, ls_w);
        if (ls_w) ls_req = 1'b0; else if_req = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("mem_write", mem_write, we);
            check("mem_waring", mem_waring, !we);
            check("mem_address", mem_address, a);
            if (we) check("mem_data_in", mem_data_in, wd);
            check("busy_no_resp", {if_valid, if_err, ls_valid, ls_err}, 4'b0);
            mem_done = (i == lat);
            mem_read_value = (i == lat) ? rv : 32'hDEAD_BEEF;
            @(negedge clk);
            if (i == lat) break;
        end
        mem_done = 1'b0;
        if (!to) begin
            if (we) mem[a] = wd;
            if (ls_w) exp_ls_rd = rv; else exp_if_rd = rv;
        end
        check("if_valid", if_valid, !ls_w && !to);
        check("ls_valid", ls_valid, ls_w && !to);
        check("if_err", if_err, !ls_w && to);
        check("ls_err", ls_err, ls_w && to);
        check("strobes_idle", {mem_write, mem_waring}, 2'b0);
        check("if_rdata", if_rdata, exp_if_rd);
        check("ls_rdata", ls_rdata, exp_ls_rd);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        check("reset_ctl", ctl(), 8'b0);
        check("reset_rdata", {if_rdata, ls_rdata}, 64'b0);
        rst = 1'b0;
        @(negedge clk);
        // single read of address 3 returning 70, one-cycle memory
        mem[3] = 70;
        if_req = 1'b1; if_addr = 3;
        serve(0, 0);
        check("read3_value", if_rdata, 70);
        // write 80 to address 4, then read it back
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 4; ls_wdata = 80;
        serve(1, 32'h1234);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 4;
        serve(0, 0);
        check("readback4", ls_rdata, 80);
        // contention: IF held high across three LS transactions
        if_req = 1'b1; if_addr = 7;
        for (int k = 0; k < 3; k++) begin
            if (!ls_req) begin
                ls_req = 1'b1; ls_we = k[0]; ls_addr = 10'(k + 8); ls_wdata = $urandom;
            end
            serve($urandom_range(0, 2), $urandom);
        end
        while (if_req || ls_req) serve(0, $urandom);
        // timeout on an LS read, then a normal request
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 5;
        serve(100, 0);
        if_req = 1'b1; if_addr = 5;
        serve(2, 0);
        // mem_done while idle must be ignored
        mem_done = 1'b1;
        repeat (2) @(negedge clk);
        mem_done = 1'b0;
        check("idle_done_ignored", ctl(), 8'b0);
        // reset in the second BUSY cycle aborts silently
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 6; ls_wdata = 99;
        @(negedge clk);
        check("abort_gnt", ls_gnt, 1'b1);
        ls_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctl", ctl(), 8'b0);
        check("abort_rdata", {if_rdata, ls_rdata}, 64'b0);
        rst = 1'b0;
        exp_if_rd = '0; exp_ls_rd = '0; last_ls = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_quiet", ctl(), 8'b0);
        end
        // randomized mix
        for (int k = 0; k < 60; k++) begin
            int lat;
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = 10'($urandom_range(0, 15));
            end
            if (!ls_req && $urandom_range(0, 1) == 1) begin
                ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
                ls_addr = 10'($urandom_range(0, 15)); ls_wdata = $urandom;
            end
            if (!if_req && !ls_req) begin
                if_req = 1'b1; if_addr = 10'($urandom_range(0, 15));
            end
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 3);
            serve(lat, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 10, word address width into main_memory.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter TIMEOUT, 16, maximum cycles in BUSY waiting for mem_done, range 2..255.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_W, if_gnt output 1, if_valid output 1, if_rdata output DATA_W, if_err output 1, forming the read-only fetch requester.
REQ-007 SHALL have ports ls_req input 1, ls_we input 1, ls_addr input ADDR_W, ls_wdata input DATA_W, ls_gnt output 1, ls_valid output 1, ls_rdata output DATA_W, ls_err output 1, forming the load/store requester.
REQ-008 SHALL have ports mem_address output ADDR_W, mem_data_in output DATA_W, mem_write output 1, mem_waring output 1 (read strobe), mem_done input 1, mem_read_value input DATA_W, driving the main_memory instance.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS.
REQ-010 In IDLE, any sampled request SHALL cause the next state BUSY_IF or BUSY_LS, capturing the winner's address, write data and write flag into registers.
REQ-011 Fixed priority (default) SHALL grant the LS requester when both requests are high.
REQ-012 x_gnt SHALL pulse high for exactly the first cycle of BUSY_x; the requester holds its request fields stable until it sees the gnt pulse, then drops req.
REQ-013 In BUSY_x, the block SHALL drive mem_address and mem_data_in from the captured registers, with mem_write = captured write flag and mem_waring = its inverse; in IDLE both strobes SHALL be 0.
REQ-014 if_req SHALL always issue a read; ls_we = 1 SHALL issue a write.
REQ-015 mem_done sampled high in BUSY_x SHALL cause the next state IDLE and a one-cycle x_valid pulse, with x_rdata loaded from mem_read_value (also loaded on writes).
REQ-016 x_rdata SHALL hold its value until the next x_valid pulse.
REQ-017 A cycle counter SHALL clear on BUSY entry and increment each BUSY cycle; reaching TIMEOUT without mem_done SHALL cause the next state IDLE, a one-cycle x_err pulse, and no x_valid pulse, leaving x_rdata unchanged.
REQ-018 If mem_done and timeout coincide, mem_done SHALL take precedence (valid, no err).
REQ-019 The cycle carrying x_valid or x_err SHALL be an IDLE cycle that arbitrates, so a pending request is granted with one idle cycle between transactions.
REQ-020 mem_done sampled in IDLE SHALL be ignored.
REQ-021 Zero-latency best case: request high at edge N, gnt in cycle N+1, mem_done at edge N+2, valid in cycle N+2.

Reset
REQ-022 While rst is sampled high, the block SHALL enter IDLE and clear the counter, the captured registers, both rdata registers, and all gnt, valid and err outputs to 0; mem strobes SHALL be 0 in the following cycle.
REQ-023 A reset during BUSY SHALL abort the transaction with no valid or err pulse.
REQ-024 Reset SHALL set last_grant = IF.

Configuration
REQ-025 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester opposite last_grant, and last_grant SHALL update on every grant.
REQ-026 Without MEM_ARB_RR_EN, the block SHALL use fixed LS priority and no last_grant register SHALL exist.

Verification
REQ-027 Single read: if_req, if_addr=3; memory returns 70 with done 1 cycle after strobe -> if_gnt pulse, mem_waring=1 and mem_address=3 for one cycle, if_valid with if_rdata=70.
REQ-028 Write: ls_req, ls_we=1, ls_addr=4, ls_wdata=80 -> mem_write=1, mem_data_in=80, mem_address=4, ls_valid after done; a later LS read of address 4 returns 80.
REQ-029 Contention, fixed priority: if_req and ls_req high together in 3 consecutive transactions -> LS granted every time, IF granted only after ls_req drops.
REQ-030 Contention, MEM_ARB_RR_EN: both requesters continuously high -> grants alternate LS, IF, LS, IF starting with LS after reset.
REQ-031 Timeout: mem_done held low, TIMEOUT=16 -> ls_err pulse 16 cycles after grant, no ls_valid, strobes 0 afterwards, next request served normally.
REQ-032 Reset mid-BUSY: rst asserted in the second BUSY cycle -> IDLE, strobes 0 the next cycle, no valid or err pulse, all outputs 0.
